// File: rtl/mem_copy_dma.sv
// Word-copy DMA initiator on the native valid/ready memory bus: one read then one write per word,
// ascending addresses, with a stall timeout that aborts the copy and flags err.
module mem_copy_dma #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_src_ptr, r_dst_ptr, r_buf, r_wait_cnt;
    logic [LEN_W-1:0] r_remaining;
    logic             r_busy, r_done, r_err, r_mem_valid;
    logic [31:0]      r_mem_addr, r_mem_wdata;
    logic [3:0]       r_mem_wstrb;

    logic [31:0]      w_src_nxt, w_dst_nxt, w_buf_nxt, w_addr_nxt, w_wdata_nxt;
    logic [LEN_W-1:0] w_remaining_nxt;
    logic             w_busy_nxt, w_done_nxt, w_err_nxt, w_valid_nxt;
    logic [3:0]       w_wstrb_nxt;
    logic             w_hs, w_timeout;

    // Handshake: a transfer completes on any posedge where mem_valid and mem_ready are both 1.
    // mem_valid, once raised, stays high with addr/wdata/wstrb frozen until that edge or a timeout.
    assign w_hs      = r_mem_valid & mem_ready;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && r_mem_valid && !mem_ready &&
                       (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = (len_words == '0) ? S_FIN : S_RD;
            S_RD: begin
                if (w_hs)           w_state_nxt = S_WR;
                else if (w_timeout) w_state_nxt = S_FIN;
            end
            S_WR: begin
                if (w_hs)           w_state_nxt = (r_remaining == LEN_W'(1)) ? S_FIN : S_RD;
                else if (w_timeout) w_state_nxt = S_FIN;
            end
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_src_nxt       = r_src_ptr;
        w_dst_nxt       = r_dst_ptr;
        w_buf_nxt       = r_buf;
        w_remaining_nxt = r_remaining;
        case (r_state)
            S_IDLE: if (start) begin
                w_src_nxt       = {src_addr[31:2], 2'b00};
                w_dst_nxt       = {dst_addr[31:2], 2'b00};
                w_remaining_nxt = len_words;
            end
            S_RD: if (w_hs) begin
                w_src_nxt = r_src_ptr + 32'd4;
                w_buf_nxt = mem_rdata;
            end
            S_WR: if (w_hs) begin
                w_dst_nxt       = r_dst_ptr + 32'd4;
                w_remaining_nxt = r_remaining - LEN_W'(1);
            end
            default: ;
        endcase
    end

    // Outputs are computed from the next state so they land in registers aligned with it.
    always_comb begin
        w_busy_nxt  = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
        w_done_nxt  = (w_state_nxt == S_FIN);
        w_valid_nxt = w_busy_nxt;
        w_wstrb_nxt = (w_state_nxt == S_WR) ? 4'hF : 4'h0;
        w_addr_nxt  = r_mem_addr;
        w_wdata_nxt = r_mem_wdata;
        if (w_state_nxt == S_RD) w_addr_nxt = w_src_nxt;
        if (w_state_nxt == S_WR) begin
            w_addr_nxt  = w_dst_nxt;
            w_wdata_nxt = w_buf_nxt;
        end
        w_err_nxt = r_err;
        if (r_state == S_IDLE && start) w_err_nxt = 1'b0;
        else if (w_timeout)             w_err_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_buf       <= '0;
            r_remaining <= '0;
            r_wait_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_src_ptr   <= w_src_nxt;
            r_dst_ptr   <= w_dst_nxt;
            r_buf       <= w_buf_nxt;
            r_remaining <= w_remaining_nxt;
            if (w_hs || !r_mem_valid)
                r_wait_cnt <= '0;
            else if (TIMEOUT_CYCLES != 0)
                r_wait_cnt <= r_wait_cnt + 32'd1;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_mem_valid <= w_valid_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_mem_wstrb <= w_wstrb_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign mem_valid = r_mem_valid;
    assign mem_instr = 1'b0;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: bus responder with stall modes, word-level copy model feeding an
// expected-transaction queue, and a monitor that pops and compares every handshake.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_words;
  logic        busy, done, err;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  dbg_state;

  mem_copy_dma #(.LEN_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .err(err), .mem_valid(mem_valid),
    .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memories: bus-side and reference ----------------
  logic [31:0] sim_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] sim_rd(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [67:0] exp_q[$];
  logic [67:0] obs_q[$];

  // Word-level copy model: read src word i, write it to dst word i, ascending, 32-bit wrap.
  task automatic push_expected(input logic [31:0] s, input logic [31:0] d, input int len);
    logic [31:0] sp, dp, v;
    sp = {s[31:2], 2'b00};
    dp = {d[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      v = ref_rd(sp);
      exp_q.push_back({4'h0, sp, v});
      ref_mem[dp] = v;
      exp_q.push_back({4'hF, dp, v});
      sp = sp + 32'd4;
      dp = dp + 32'd4;
    end
  endtask

  // ---------------- responder: 0=always ready, 1=stall 3, 2=random stall 0..3, 3=never ready ----------------
  int          ready_mode = 0;
  int          stall_cnt = 0;
  int          stall_tgt = 0;
  logic [67:0] held;

  always @(negedge clk) begin
    if (!resetn) begin
      mem_ready = 1'b0;
      stall_cnt = 0;
    end else if (mem_valid) begin
      if (stall_cnt > 0)
        check("req_stable", {mem_wstrb, mem_addr, mem_wdata}, held);
      if (ready_mode != 3 && stall_cnt >= stall_tgt) begin
        mem_ready = 1'b1;
        if (mem_wstrb == 4'h0) begin
          mem_rdata = sim_rd(mem_addr);
          obs_q.push_back({mem_wstrb, mem_addr, mem_rdata});
        end else begin
          sim_mem[mem_addr] = mem_wdata;
          obs_q.push_back({mem_wstrb, mem_addr, mem_wdata});
        end
        stall_cnt = 0;
        stall_tgt = (ready_mode == 1) ? 3 : (ready_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      end else begin
        mem_ready = 1'b0;
        if (stall_cnt == 0) held = {mem_wstrb, mem_addr, mem_wdata};
        stall_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      stall_cnt = 0;
      stall_tgt = (ready_mode == 1) ? 3 : (ready_mode == 2) ? int'($urandom_range(0, 3)) : 0;
    end
  end

  // ---------------- monitor ----------------
  logic [67:0] mon_o, mon_e;
  always @(posedge clk) begin
    #1;
    while (obs_q.size() > 0) begin
      mon_o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_txn: got %0h expected none", mon_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("txn", mon_o, mon_e);
      end
      check("mem_instr", {67'b0, mem_instr}, 68'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len, input int mode,
                          input bit exp_err, input int exp_lat, input int exp_busy,
                          input int exp_valid, input bit poke_busy, input bit poke_done);
    int  s0, busy_n, valid_n;
    bit  got;
    ready_mode = mode;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len_words = 16'(len);
    s0 = cyc;
    if (!exp_err) push_expected(s, d, len);
    @(negedge clk);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len_words = 16'($urandom_range(1, 9));
    got = 0; busy_n = 0; valid_n = 0;
    for (int k = 0; k < 3000; k++) begin
      if (busy) busy_n++;
      if (mem_valid) valid_n++;
      if (done) begin
        got = 1;
        break;
      end
      start = (poke_busy && busy && k == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", {67'b0, got}, 68'd1);
    if (got) begin
      check("err", {67'b0, err}, {67'b0, exp_err});
      if (exp_lat >= 0)   check("latency", 68'(cyc - s0 + 1), 68'(exp_lat));
      if (exp_busy >= 0)  check("busy_cycles", 68'(busy_n), 68'(exp_busy));
      if (exp_valid >= 0) check("valid_cycles", 68'(valid_n), 68'(exp_valid));
      check("exp_q_drained", 68'(exp_q.size()), 68'd0);
      check("valid_at_done", {67'b0, mem_valid}, 68'd0);
    end
    if (poke_done) begin
      start = 1'b1; src_addr = 32'h0001_1000; dst_addr = 32'h0001_2000; len_words = 16'd3;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_pulse", {67'b0, done}, 68'd0);
    if (poke_done) begin
      repeat (2) @(negedge clk);
      check("start_at_done_ignored", {66'b0, busy, mem_valid}, 68'd0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, {63'b0, busy, done, err, mem_valid, mem_instr}, 68'd0);
    check({tag, "_bus"}, {mem_wstrb, mem_addr, mem_wdata}, 68'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rs, rd;
    int          rl, rm;
    resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    resetn = 1'b1;

    // single word, known data
    sim_mem[32'h0001_0000] = 32'hDEADBEEF;
    ref_mem[32'h0001_0000] = 32'hDEADBEEF;
    run_copy(32'h0001_0000, 32'h0001_0100, 1, 0, 1'b0, 4, 2, 2, 1'b0, 1'b0);
    check("mem_word1", {36'b0, sim_rd(32'h0001_0100)}, {36'b0, 32'hDEADBEEF});

    // unaligned source, four words; also a start landing on done
    run_copy(32'h0001_0003, 32'h0001_0200, 4, 0, 1'b0, 10, 8, 8, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      check("mem_len4", {36'b0, sim_rd(32'h0001_0200 + 32'(4 * i))},
            {36'b0, ref_rd(32'h0001_0200 + 32'(4 * i))});

    // zero length
    run_copy(32'h0001_0400, 32'h0001_0500, 0, 0, 1'b0, 2, 0, 0, 1'b0, 1'b0);

    // fixed 3-cycle stall per request
    run_copy(32'h0001_0600, 32'h0001_0700, 2, 1, 1'b0, 18, 16, 16, 1'b0, 1'b0);

    // pointer wrap at the top of the address space
    run_copy(32'hFFFF_FFF8, 32'h0007_0000, 4, 0, 1'b0, 10, 8, 8, 1'b0, 1'b0);

    // overlapping ranges, ascending copy
    run_copy(32'h0006_0000, 32'h0006_0008, 4, 2, 1'b0, -1, -1, -1, 1'b0, 1'b0);

    // timeout abort, with a start poked while busy
    run_copy(32'h0008_0000, 32'h0008_0100, 3, 3, 1'b1, 10, 8, 8, 1'b1, 1'b0);
    run_copy(32'h0008_0200, 32'h0008_0300, 1, 0, 1'b0, 4, 2, 2, 1'b0, 1'b0);

    // randomized copies
    for (int it = 0; it < 6; it++) begin
      rl = int'($urandom_range(1, 6));
      rm = int'($urandom_range(0, 2));
      rs = 32'h0004_0000 + 32'(it * 256) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      rd = 32'h0005_0000 + 32'(it * 256) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if (rm == 0) run_copy(rs, rd, rl, 0, 1'b0, 2 * rl + 2, 2 * rl, 2 * rl, 1'b0, 1'b0);
      else         run_copy(rs, rd, rl, rm, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    end

    // reset mid-copy
    ready_mode = 0;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h0003_0000; dst_addr = 32'h0003_0100; len_words = 16'd8;
    push_expected(32'h0003_0000, 32'h0003_0100, 8);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_copy", {67'b0, busy}, 68'd1);
    #2 resetn = 1'b0;
    #1 check_idle_outputs("async_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_done_in_reset", {66'b0, done, mem_valid}, 68'd0);
    end
    exp_q.delete();
    obs_q.delete();
    resetn = 1'b1;
    run_copy(32'h0003_0400, 32'h0003_0500, 1, 0, 1'b0, 4, 2, 2, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
